// File: rtl/nn_pkg.sv
// Shared definitions for the inter-layer stream blocks.
// Includes the word type, serializer states and lane index sizing.
package nn_pkg;

    localparam int DATA_WIDTH_DEF = 16;

    typedef logic signed [DATA_WIDTH_DEF-1:0] word_t;

    typedef enum logic [1:0] {
        IDLE,
        PRIME,
        STREAM,
        DONE
    } state_t;

    // A one-lane frame still needs a 1-bit index to stay a legal vector.
    function automatic int lane_idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/layer_serializer_if.sv
// Stream bundle around the serializer.
// Carries the parallel lanes of one layer in and the serial word stream out.
interface layer_serializer_if
    import nn_pkg::*;
#(
    parameter int NUM_NEURONS = 128,
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH  = 32
) ();

    logic [NUM_NEURONS-1:0]            in_valids;
    logic [NUM_NEURONS*DATA_WIDTH-1:0] layer_in;
    logic [DATA_WIDTH-1:0]             data_out;
    logic                              out_valid;
    logic [ADDR_WIDTH-1:0]             addr_out;

    modport master (
        output in_valids,
        output layer_in,
        input  data_out,
        input  out_valid,
        input  addr_out
    );

    modport slave (
        input  in_valids,
        input  layer_in,
        output data_out,
        output out_valid,
        output addr_out
    );

endinterface

// File: rtl/layer_frame_buffer.sv
// Per-lane capture store for one layer frame.
// Also holds the lane arrival mask, the frame-complete detect and an indexed read port.
module layer_frame_buffer
    import nn_pkg::*;
#(
    parameter int NUM_NEURONS = 128,
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int IDX_WIDTH   = lane_idx_width(NUM_NEURONS)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              i_capEn,
    input  logic                              i_clearMask,
    input  logic [NUM_NEURONS-1:0]            i_valids,
    input  logic [NUM_NEURONS*DATA_WIDTH-1:0] i_lanes,
    input  logic [IDX_WIDTH-1:0]              i_rdIdx,
    output logic [DATA_WIDTH-1:0]             o_rdData,
    output logic                              o_full
);

    logic [DATA_WIDTH-1:0]  r_buf [NUM_NEURONS];
    logic [NUM_NEURONS-1:0] r_mask;
    logic [NUM_NEURONS-1:0] w_strobes;

    assign w_strobes = i_capEn ? i_valids : '0;
    assign o_full    = i_capEn && (&(r_mask | i_valids));
    assign o_rdData  = r_buf[i_rdIdx];

    // The store is not reset: a lane only counts once its mask bit is set.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_NEURONS; i++) begin
            if (w_strobes[i]) begin
                r_buf[i] <= i_lanes[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mask <= '0;
        end else if (i_clearMask) begin
            r_mask <= '0;
        end else begin
            r_mask <= r_mask | w_strobes;
        end
    end

endmodule

// File: rtl/layer_serializer.sv
// Layer result serializer: captures a parallel frame, then replays it one word per clock.
// The weight address leads the data by one cycle. LAYER_SERIALIZER_ARGMAX_EN adds a frame argmax.
module layer_serializer
    import nn_pkg::*;
#(
    parameter int NUM_NEURONS = 128,
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH  = 32
) (
    input  logic              clk,
    input  logic              rst,
    layer_serializer_if.slave bus,
    output logic              busy,
    output logic              done,
    output logic              overrun
`ifdef LAYER_SERIALIZER_ARGMAX_EN
    ,
    output logic [lane_idx_width(NUM_NEURONS)-1:0] argmax_idx,
    output logic [DATA_WIDTH-1:0]                  argmax_val
`endif
);

    localparam int                   IDX_WIDTH = lane_idx_width(NUM_NEURONS);
    localparam logic [IDX_WIDTH-1:0] LAST_IDX  = IDX_WIDTH'(NUM_NEURONS - 1);

    state_t                r_state;
    state_t                w_nextState;
    logic [IDX_WIDTH-1:0]  r_count;
    logic [IDX_WIDTH-1:0]  w_nextCount;
    logic [DATA_WIDTH-1:0] r_dataOut;
    logic [DATA_WIDTH-1:0] w_rdData;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH-1:0] w_nextAddr;
    logic                  r_outValid;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_overrun;
    logic                  w_full;
    logic                  w_capEn;
    logic                  w_clearMask;

    assign w_capEn     = (r_state == IDLE);
    assign w_clearMask = (r_state == PRIME);

    layer_frame_buffer #(
        .NUM_NEURONS (NUM_NEURONS),
        .DATA_WIDTH  (DATA_WIDTH),
        .IDX_WIDTH   (IDX_WIDTH)
    ) u_frameBuffer (
        .clk         (clk),
        .rst         (rst),
        .i_capEn     (w_capEn),
        .i_clearMask (w_clearMask),
        .i_valids    (bus.in_valids),
        .i_lanes     (bus.layer_in),
        .i_rdIdx     (w_nextCount),
        .o_rdData    (w_rdData),
        .o_full      (w_full)
    );

    // Outputs are registered from the next state, so the address is prepared one beat ahead.
    always_comb begin
        w_nextState = r_state;
        w_nextCount = r_count;
        w_nextAddr  = '0;
        case (r_state)
            IDLE: begin
                if (w_full) begin
                    w_nextState = PRIME;
                end
            end
            PRIME: begin
                w_nextState = STREAM;
                w_nextCount = '0;
            end
            STREAM: begin
                if (r_count == LAST_IDX) begin
                    w_nextState = DONE;
                end else begin
                    w_nextCount = r_count + IDX_WIDTH'(1);
                end
            end
            DONE: begin
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
        if ((w_nextState == STREAM) && (w_nextCount != LAST_IDX)) begin
            w_nextAddr = ADDR_WIDTH'(w_nextCount) + ADDR_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_count <= '0;
        end else begin
            r_state <= w_nextState;
            r_count <= w_nextCount;
        end
    end

    // data_out is only reloaded for stream beats and otherwise keeps its last word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_dataOut  <= '0;
            r_outValid <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_addr     <= '0;
            r_overrun  <= 1'b0;
        end else begin
            r_outValid <= (w_nextState == STREAM);
            r_busy     <= (w_nextState == PRIME) || (w_nextState == STREAM);
            r_done     <= (w_nextState == DONE);
            r_addr     <= w_nextAddr;
            if (w_nextState == STREAM) begin
                r_dataOut <= w_rdData;
            end
            if ((r_state != IDLE) && (|bus.in_valids)) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign bus.data_out  = r_dataOut;
    assign bus.out_valid = r_outValid;
    assign bus.addr_out  = r_addr;
    assign busy          = r_busy;
    assign done          = r_done;
    assign overrun       = r_overrun;

`ifdef LAYER_SERIALIZER_ARGMAX_EN
    logic [IDX_WIDTH-1:0]  r_runIdx;
    logic [IDX_WIDTH-1:0]  r_argIdx;
    logic [IDX_WIDTH-1:0]  w_candIdx;
    logic [DATA_WIDTH-1:0] r_runVal;
    logic [DATA_WIDTH-1:0] r_argVal;
    logic [DATA_WIDTH-1:0] w_candVal;

    // A strict compare keeps the earliest lane on ties.
    always_comb begin
        w_candIdx = r_runIdx;
        w_candVal = r_runVal;
        if ((r_count == '0) || ($signed(r_dataOut) > $signed(r_runVal))) begin
            w_candIdx = r_count;
            w_candVal = r_dataOut;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_runIdx <= '0;
            r_runVal <= '0;
            r_argIdx <= '0;
            r_argVal <= '0;
        end else if (r_state == STREAM) begin
            r_runIdx <= w_candIdx;
            r_runVal <= w_candVal;
            if (r_count == LAST_IDX) begin
                r_argIdx <= w_candIdx;
                r_argVal <= w_candVal;
            end
        end
    end

    assign argmax_idx = r_argIdx;
    assign argmax_val = r_argVal;
`endif

endmodule

// File: tb/tb_layer_serializer.sv
// Self-checking bench for layer_serializer with a 4-lane frame.
// Uses a directed vector table, hand-written corner sequences and randomized frames against a frame-level model.
module tb_layer_serializer;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int AW = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic busy;
    logic done;
    logic overrun;
`ifdef LAYER_SERIALIZER_ARGMAX_EN
    logic [1:0]    argmax_idx;
    logic [DW-1:0] argmax_val;
`endif

    layer_serializer_if #(.NUM_NEURONS(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    layer_serializer #(.NUM_NEURONS(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .busy       (busy),
        .done       (done),
        .overrun    (overrun)
`ifdef LAYER_SERIALIZER_ARGMAX_EN
        ,
        .argmax_idx (argmax_idx),
        .argmax_val (argmax_val)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0]    s;
        logic [N*DW-1:0] d;
        logic            v;
        logic [DW-1:0]   data;
        logic [AW-1:0]   addr;
        logic            b;
        logic            dn;
    } vec_t;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Frame-level reference: lane store, arrival mask, completion cycle and snapshot.
    logic [DW-1:0] mBuf [N];
    logic [DW-1:0] mFrame [N];
    logic [N-1:0]  mMask;
    logic          mOverrun;
    int            mT;
    int            mArgIdx;
    logic [DW-1:0] mArgVal;
    int            pArgIdx;
    logic [DW-1:0] pArgVal;

    function automatic logic [N*DW-1:0] pack4(input logic [DW-1:0] l0, input logic [DW-1:0] l1,
                                             input logic [DW-1:0] l2, input logic [DW-1:0] l3);
        return {l3, l2, l1, l0};
    endfunction

    task automatic cmp(input string name, input logic [AW-1:0] got, input logic [AW-1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cyc, got, want);
        end
    endtask

    task automatic checkOutput(input string tag, input logic eValid, input logic [DW-1:0] eData,
                               input logic [AW-1:0] eAddr, input logic eBusy, input logic eDone,
                               input logic eOverrun);
        cmp({tag, " out_valid"}, AW'(bus.out_valid), AW'(eValid));
        if (eValid) begin
            cmp({tag, " data_out"}, AW'(bus.data_out), AW'(eData));
        end
        cmp({tag, " addr_out"}, bus.addr_out, eAddr);
        cmp({tag, " busy"}, AW'(busy), AW'(eBusy));
        cmp({tag, " done"}, AW'(done), AW'(eDone));
        cmp({tag, " overrun"}, AW'(overrun), AW'(eOverrun));
    endtask

    task automatic applyStimulus(input logic [N-1:0] s, input logic [N*DW-1:0] d);
        bus.in_valids = s;
        bus.layer_in  = d;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic modelReset();
        mMask    = '0;
        mOverrun = 1'b0;
        mT       = -1000;
        mArgIdx  = 0;
        mArgVal  = '0;
    endtask

    // Check this cycle's outputs against the model, then let the model see the strobes and drive them.
    task automatic runCycle(input logic [N-1:0] s, input logic [N*DW-1:0] d);
        int            dl;
        int            k;
        logic          eV;
        logic          eB;
        logic          eD;
        logic [DW-1:0] eData;
        logic [AW-1:0] eA;
        dl    = cyc - mT;
        k     = dl - 2;
        eB    = (dl >= 1) && (dl <= N + 1);
        eV    = (dl >= 2) && (dl <= N + 1);
        eD    = (dl == N + 2);
        eData = eV ? mFrame[k] : '0;
        eA    = (eV && (k < N - 1)) ? AW'(k + 1) : '0;
        if (eD) begin
            mArgIdx = pArgIdx;
            mArgVal = pArgVal;
        end
        checkOutput("model", eV, eData, eA, eB, eD, mOverrun);
`ifdef LAYER_SERIALIZER_ARGMAX_EN
        cmp("model argmax_idx", AW'(argmax_idx), AW'(mArgIdx));
        cmp("model argmax_val", AW'(argmax_val), AW'(mArgVal));
`endif
        if ((dl >= 1) && (dl <= N + 2)) begin
            if (|s) mOverrun = 1'b1;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (s[i]) begin
                    mBuf[i]  = d[i*DW +: DW];
                    mMask[i] = 1'b1;
                end
            end
            if (&mMask) begin
                mT    = cyc;
                mMask = '0;
                for (int i = 0; i < N; i++) mFrame[i] = mBuf[i];
                pArgIdx = 0;
                pArgVal = mFrame[0];
                for (int i = 1; i < N; i++) begin
                    if ($signed(mFrame[i]) > $signed(pArgVal)) begin
                        pArgIdx = i;
                        pArgVal = mFrame[i];
                    end
                end
            end
        end
        applyStimulus(s, d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) runCycle('0, '0);
    endtask

    vec_t tbl [8];

    initial begin
        bus.in_valids = '0;
        bus.layer_in  = '0;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;

        // All four lanes in one cycle T, outputs followed cycle by cycle.
        tbl[0] = '{s: 4'hF, d: pack4(16'h0001, 16'h0002, 16'h0003, 16'h0004),
                   v: 1'b0, data: 16'h0, addr: 32'd0, b: 1'b0, dn: 1'b0};
        tbl[1] = '{s: 4'h0, d: '0, v: 1'b0, data: 16'h0, addr: 32'd0, b: 1'b1, dn: 1'b0};
        tbl[2] = '{s: 4'h0, d: '0, v: 1'b1, data: 16'h1, addr: 32'd1, b: 1'b1, dn: 1'b0};
        tbl[3] = '{s: 4'h0, d: '0, v: 1'b1, data: 16'h2, addr: 32'd2, b: 1'b1, dn: 1'b0};
        tbl[4] = '{s: 4'h0, d: '0, v: 1'b1, data: 16'h3, addr: 32'd3, b: 1'b1, dn: 1'b0};
        tbl[5] = '{s: 4'h0, d: '0, v: 1'b1, data: 16'h4, addr: 32'd0, b: 1'b1, dn: 1'b0};
        tbl[6] = '{s: 4'h0, d: '0, v: 1'b0, data: 16'h0, addr: 32'd0, b: 1'b0, dn: 1'b1};
        tbl[7] = '{s: 4'h0, d: '0, v: 1'b0, data: 16'h0, addr: 32'd0, b: 1'b0, dn: 1'b0};
        for (int i = 0; i < 8; i++) begin
            checkOutput($sformatf("vec%0d", i), tbl[i].v, tbl[i].data, tbl[i].addr,
                        tbl[i].b, tbl[i].dn, 1'b0);
            applyStimulus(tbl[i].s, tbl[i].d);
        end
        modelReset();
        mArgIdx = 3;
        mArgVal = 16'h0004;

        // Out-of-order arrival 3,0,2,1: replay is in index order.
        runCycle(4'b1000, pack4(16'h0, 16'h0, 16'h0, 16'h0333));
        runCycle(4'b0001, pack4(16'h0AAA, 16'h0, 16'h0, 16'h0));
        runCycle(4'b0100, pack4(16'h0, 16'h0, 16'h0222, 16'h0));
        runCycle(4'b0010, pack4(16'h0, 16'h0111, 16'h0, 16'h0));
        idle(N + 4);

        // Lane 2 rewritten before completion is not an error.
        runCycle(4'b0100, pack4(16'h0, 16'h0, 16'h0010, 16'h0));
        runCycle(4'b0100, pack4(16'h0, 16'h0, 16'h0020, 16'h0));
        runCycle(4'b1011, pack4(16'h0007, 16'h0008, 16'hBEEF, 16'h0009));
        idle(N + 4);
        cmp("rewrite overrun", AW'(overrun), AW'(0));

        // Strobe during the stream: sticky overrun, frame untouched, next frame needs all lanes.
        runCycle(4'b1111, pack4(16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0));
        runCycle(4'b0000, '0);
        runCycle(4'b0001, pack4(16'h7777, 16'h0, 16'h0, 16'h0));
        idle(N + 2);
        runCycle(4'b0111, pack4(16'h0101, 16'h0202, 16'h0303, 16'h0));
        idle(5);
        runCycle(4'b1000, pack4(16'h0, 16'h0, 16'h0, 16'h0404));
        idle(N + 4);
        cmp("overrun sticky", AW'(overrun), AW'(1));

        // Reset during beat 2 of the stream drops out_valid without a clock edge.
        runCycle(4'b1111, pack4(16'h0011, 16'h0022, 16'h0033, 16'h0044));
        runCycle('0, '0);
        runCycle('0, '0);
        runCycle('0, '0);
        cmp("pre-reset out_valid", AW'(bus.out_valid), AW'(1));
        rst = 1'b0;
        #1;
        cmp("async reset out_valid", AW'(bus.out_valid), AW'(0));
        cmp("async reset busy", AW'(busy), AW'(0));
        cmp("async reset overrun", AW'(overrun), AW'(0));
        applyStimulus('0, '0);
        applyStimulus('0, '0);
        rst = 1'b1;
        modelReset();
        idle(3);
        runCycle(4'b0011, pack4(16'h0A01, 16'h0A02, 16'h0, 16'h0));
        idle(4);
        runCycle(4'b1100, pack4(16'h0, 16'h0, 16'h0A03, 16'h0A04));
        idle(N + 4);

        // Signed maximum with a tie and negative extremes.
        runCycle(4'b1111, pack4(16'hFFF0, 16'h0005, 16'h0005, 16'h8000));
        idle(N + 3);
`ifdef LAYER_SERIALIZER_ARGMAX_EN
        cmp("argmax_idx tie", AW'(argmax_idx), AW'(1));
        cmp("argmax_val tie", AW'(argmax_val), AW'(16'h0005));
`endif

        // Randomized strobes and data.
        for (int i = 0; i < 600; i++) begin
            logic [N-1:0]    s;
            logic [N*DW-1:0] d;
            s = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
            d = {$urandom, $urandom};
            runCycle(s, d);
        end
        idle(N + 4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
